calc_engine: RTL and testbench
==============================

Name: calc_engine

Overview:
- Parametrised, clocked successor of the calculator datapath.
- Holds two DIGITS-wide BCD operands, entered by per-digit increment strobes.
- Runs add, subtract, multiply or rounded divide as a multi-cycle FSM with a ready/busy/done handshake, then converts the result back to BCD.
- Sits between the debounced button front-end and the seven-segment scan logic; drives the digits to be displayed plus the negative and error flags.

Parameters:
DIGITS, 2, decimal digits per operand (1..4)
OUT_DIGITS, 2*DIGITS, result digits; fixed relation, not user-overridable
W, clog2(10**DIGITS), binary operand width (derived localparam; 7 for DIGITS=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
inc  in  2*DIGITS  single-cycle increment strobes; bits [DIGITS-1:0] = operand B digits (bit 0 = ones), bits [2*DIGITS-1:DIGITS] = operand A digits
clear  in  1  single-cycle strobe: zero operands, abort any operation
op_valid  in  1  request operation
op  in  2  0=add 1=sub 2=mul 3=div
op_ready  out  1  high only in IDLE
busy  out  1  high from the accept edge until done
done  out  1  one-cycle pulse when the result is valid
res_bcd  out  4*OUT_DIGITS  result, BCD, MS digit at top
res_neg  out  1  result is negative (sub only)
res_err  out  1  divide by zero
show_result  out  1  display selects result (1) or operands (0)
disp_bcd  out  4*OUT_DIGITS  show_result ? res_bcd : {A_bcd, B_bcd}

Behaviour:
- Reset (rst=0, async): operands 0, res_bcd 0, res_neg/res_err/done/busy/show_result 0, op_ready 1, FSM IDLE. A reset mid-operation discards everything.
- Increment: each strobed digit advances 0..9 with 9 wrapping to 0. Multiple bits in one cycle are all applied. Strobes are ignored when not IDLE. Any applied strobe clears show_result.
- Handshake: an op is accepted on an edge with op_valid && op_ready. A same-cycle inc is dropped and the op uses the registered operands. op is latched at accept; op_valid is ignored while busy.
- FSM:
  - IDLE -> CONV on accept.
  - CONV: DIGITS cycles, one digit per cycle, MS first, acc = acc*10 + digit for both operands in parallel -> EXEC.
  - EXEC:
    - add, sub, mul: 1 cycle.
    - div: W cycles, restoring, one quotient bit per cycle. Final cycle adds 1 to the quotient when 2*remainder >= divisor (round half up).
    - div with divisor 0: EXEC takes 1 cycle, result 0, res_err=1.
  - BCD: 2W cycles of iterative double-dabble on a 2W-bit value -> DONE.
  - DONE: 1 cycle; done=1, res_* updated, show_result=1 -> IDLE.
- Latency from accept edge to done high: DIGITS + 1 + 2W + 1 for add/sub/mul and div-by-0, DIGITS + W + 2W + 1 for div. For DIGITS=2 that is 18 and 24 cycles.
- Arithmetic widths:
  - Sum is W+1 bits; product is 2W bits, and (10^D-1)^2 < 10^(2D) always fits OUT_DIGITS.
  - Sub: if A<B the result is B-A with res_neg=1, else A-B with res_neg=0. A zero result is never negative.
  - res_neg and res_err are cleared at every accept.
- clear: in any state, zero operands, show_result=0, FSM to IDLE, no done pulse, res_* retain their last values. clear has priority over inc and op_valid in the same cycle.

Decomposition:
- Shared package calc_pkg: op encoding constants (OP_ADD, OP_SUB, OP_MUL, OP_DIV), FSM state enum, a width helper for W.
- One sub-module: bin_to_bcd_seq. Handles the start/done iterative double-dabble, parametrised by input bits and output digits. Instantiated once; its start is driven on EXEC exit.

Test Plan:
- A=47, B=58, add -> done exactly 18 cycles after accept; res_bcd=0105, res_neg=0, show_result=1.
- A=12, B=34, sub -> res_bcd=0022, res_neg=1. Then A=34, B=34, sub -> 0000, res_neg=0.
- A=99, B=99, mul -> res_bcd=9801. Then strobe inc[0] -> B ones wraps to 0 (B=90), show_result=0, disp_bcd=9990.
- div: 07/02 -> 0004; 10/03 -> 0003; 11/02 -> 0006; 05/00 -> res_bcd=0000, res_err=1, done at 18 cycles. Non-zero divides finish at 24 cycles.
- Assert clear at cycle 5 of a div -> no done, op_ready=1 next cycle, operands 00/00. Assert rst low mid-CONV -> all outputs at reset values immediately.
- op_valid with inc[3] in the same IDLE cycle -> the op uses the old A tens digit, the increment is lost; inc and op_valid during busy are ignored.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator engine: op codes, FSM states, width helpers.
package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_CONV, S_EXEC, S_BCD, S_DONE} state_e;

  // Binary width able to hold any DIGITS-digit decimal operand.
  function automatic int calc_w(input int digits);
    int p;
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    return $clog2(p);
  endfunction

  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/calc_if.sv
// Operand entry, operation handshake and display bus of the calculator engine.
interface calc_if #(parameter int DIGITS = 2);
  localparam int OD = 2 * DIGITS;

  logic [2*DIGITS-1:0] inc;
  logic                clear;
  logic                op_valid;
  logic [1:0]          op;
  logic                op_ready;
  logic                busy;
  logic                done;
  logic [4*OD-1:0]     res_bcd;
  logic                res_neg;
  logic                res_err;
  logic                show_result;
  logic [4*OD-1:0]     disp_bcd;

  modport master (output inc, clear, op_valid, op,
                  input  op_ready, busy, done, res_bcd, res_neg, res_err, show_result, disp_bcd);
  modport slave  (input  inc, clear, op_valid, op,
                  output op_ready, busy, done, res_bcd, res_neg, res_err, show_result, disp_bcd);
endinterface

// File: rtl/calc_engine_bcd.sv
// Iterative double-dabble: one shift-and-adjust step per cycle, NB steps after start.
module bin_to_bcd_seq #(
  parameter int NB = 14,
  parameter int ND = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [NB-1:0]   bin_i,
  output logic            done_o,
  output logic [4*ND-1:0] bcd_o
);
  localparam int CW = $clog2(NB + 1);

  logic [NB-1:0]   bin_q;
  logic [4*ND-1:0] bcd_q, adj;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < ND; i++)
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      bin_q  <= bin_i;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      bcd_q <= {adj[4*ND-2:0], bin_q[NB-1]};
      bin_q <= bin_q << 1;
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == CW'(NB - 1)) busy_q <= 1'b0;
    end
  end

  // Flags the final step so the owner can move on at the same edge it completes.
  assign done_o = busy_q && (cnt_q == CW'(NB - 1));
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/calc_engine.sv
// Clocked BCD calculator: operand entry, multi-cycle add/sub/mul/rounded div, BCD result.
module calc_engine
  import calc_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  calc_if.slave bus
);
  localparam int OD = 2 * DIGITS;
  localparam int W  = calc_w(DIGITS);
  localparam int W2 = 2 * W;
  localparam int CW = $clog2(W + 1);

  state_e                  state_q;
  logic [DIGITS-1:0][3:0]  a_q, b_q;
  logic [W-1:0]            acc_a_q, acc_b_q, acc_a_d, acc_b_d;
  logic [W-1:0]            rem_q, quo_q, quo_d;
  logic [W:0]              rem_d;
  logic [CW-1:0]           cnt_q;
  logic [1:0]              op_q;
  logic                    pend_neg_q, pend_err_q;
  logic                    op_ready_q, busy_q, done_q, show_q, res_neg_q, res_err_q;
  logic [4*OD-1:0]         res_bcd_q, bcd_val;
  logic [3:0]              dig_a, dig_b;
  logic [W2-1:0]           res_bin_d;
  logic                    neg_d, err_d, exec_last, round_up, bcd_done, bcd_start;

  // Horner conversion, most significant digit first.
  always_comb begin
    dig_a = '0;
    dig_b = '0;
    for (int i = 0; i < DIGITS; i++)
      if (CW'(DIGITS - 1 - i) == cnt_q) begin
        dig_a = a_q[i];
        dig_b = b_q[i];
      end
    acc_a_d = acc_a_q * W'(10) + W'(dig_a);
    acc_b_d = acc_b_q * W'(10) + W'(dig_b);
  end

  // One restoring-division step; the first step seeds from the dividend.
  always_comb begin
    logic [W-1:0] src_rem, src_quo;
    logic [W:0]   rem_sh;
    logic         ge;
    src_rem  = (cnt_q == '0) ? '0 : rem_q;
    src_quo  = (cnt_q == '0) ? acc_a_q : quo_q;
    rem_sh   = {src_rem, src_quo[W-1]};
    ge       = rem_sh >= {1'b0, acc_b_q};
    rem_d    = ge ? rem_sh - {1'b0, acc_b_q} : rem_sh;
    quo_d    = {src_quo[W-2:0], ge};
    round_up = {rem_d, 1'b0} >= {2'b00, acc_b_q};
  end

  always_comb begin
    res_bin_d = '0;
    neg_d     = 1'b0;
    err_d     = 1'b0;
    exec_last = 1'b1;
    case (op_q)
      OP_ADD: res_bin_d = W2'(acc_a_q) + W2'(acc_b_q);
      OP_SUB: if (acc_a_q < acc_b_q) begin
                res_bin_d = W2'(acc_b_q - acc_a_q);
                neg_d     = 1'b1;
              end else res_bin_d = W2'(acc_a_q - acc_b_q);
      OP_MUL: res_bin_d = W2'(acc_a_q) * W2'(acc_b_q);
      default: if (acc_b_q == '0) err_d = 1'b1;
               else begin
                 exec_last = (cnt_q == CW'(W - 1));
                 res_bin_d = W2'(quo_d) + W2'(round_up);
               end
    endcase
  end

  assign bcd_start = (state_q == S_EXEC) && exec_last;

  bin_to_bcd_seq #(.NB(W2), .ND(OD)) u_bcd (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (bcd_start),
    .bin_i   (res_bin_d),
    .done_o  (bcd_done),
    .bcd_o   (bcd_val)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      acc_a_q    <= '0;
      acc_b_q    <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      op_q       <= OP_ADD;
      pend_neg_q <= 1'b0;
      pend_err_q <= 1'b0;
      op_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      show_q     <= 1'b0;
      res_bcd_q  <= '0;
      res_neg_q  <= 1'b0;
      res_err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.clear) begin
        a_q        <= '0;
        b_q        <= '0;
        show_q     <= 1'b0;
        state_q    <= S_IDLE;
        op_ready_q <= 1'b1;
        busy_q     <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: if (bus.op_valid) begin
                    op_q       <= bus.op;
                    acc_a_q    <= '0;
                    acc_b_q    <= '0;
                    cnt_q      <= '0;
                    res_neg_q  <= 1'b0;
                    res_err_q  <= 1'b0;
                    op_ready_q <= 1'b0;
                    busy_q     <= 1'b1;
                    state_q    <= S_CONV;
                  end else if (|bus.inc) begin
                    show_q <= 1'b0;
                    for (int i = 0; i < DIGITS; i++) begin
                      if (bus.inc[i])          b_q[i] <= bcd_inc(b_q[i]);
                      if (bus.inc[DIGITS + i]) a_q[i] <= bcd_inc(a_q[i]);
                    end
                  end
          S_CONV: begin
                    acc_a_q <= acc_a_d;
                    acc_b_q <= acc_b_d;
                    if (cnt_q == CW'(DIGITS - 1)) begin
                      cnt_q   <= '0;
                      state_q <= S_EXEC;
                    end else cnt_q <= cnt_q + 1'b1;
                  end
          S_EXEC: begin
                    rem_q <= rem_d[W-1:0];
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (exec_last) begin
                      pend_neg_q <= neg_d;
                      pend_err_q <= err_d;
                      state_q    <= S_BCD;
                    end
                  end
          S_BCD:  if (bcd_done) state_q <= S_DONE;
          default: begin
                    done_q     <= 1'b1;
                    res_bcd_q  <= bcd_val;
                    res_neg_q  <= pend_neg_q;
                    res_err_q  <= pend_err_q;
                    show_q     <= 1'b1;
                    op_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                  end
        endcase
      end
    end
  end

  assign bus.op_ready    = op_ready_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.res_bcd     = res_bcd_q;
  assign bus.res_neg     = res_neg_q;
  assign bus.res_err     = res_err_q;
  assign bus.show_result = show_q;
  assign bus.disp_bcd    = show_q ? res_bcd_q : {a_q, b_q};

endmodule

// File: tb/tb_calc_engine.sv
// Scoreboard bench for calc_engine: directed cases plus random ops against an integer model.
module tb_calc_engine;
  localparam int D       = 2;
  localparam int OD      = 2 * D;
  localparam int W       = $clog2(10 ** D);
  localparam int LAT_S   = D + 1 + 2 * W + 1;
  localparam int LAT_DIV = D + W + 2 * W + 1;

  typedef struct {
    int val;
    bit neg;
    bit err;
    int lat;
    int acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   ma[D];
  int   mb[D];
  exp_t sb[$];

  calc_if #(.DIGITS(D)) bus();

  calc_engine #(.DIGITS(D)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [4*OD-1:0] to_bcd(input int v);
    logic [4*OD-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < OD; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int val_a();
    int v;
    v = 0;
    for (int i = D - 1; i >= 0; i--) v = v * 10 + ma[i];
    return v;
  endfunction

  function automatic int val_b();
    int v;
    v = 0;
    for (int i = D - 1; i >= 0; i--) v = v * 10 + mb[i];
    return v;
  endfunction

  function automatic logic [4*OD-1:0] opnd_bcd();
    return (to_bcd(val_a()) << (4 * D)) | to_bcd(val_b());
  endfunction

  // Done monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done res=%0h", bus.res_bcd);
      end else begin
        e = sb.pop_front();
        chk("res_bcd", 32'(bus.res_bcd), 32'(to_bcd(e.val)));
        chk("res_neg", 32'(bus.res_neg), 32'(e.neg));
        chk("res_err", 32'(bus.res_err), 32'(e.err));
        chk("latency", 32'(cyc - e.acc), 32'(e.lat));
        chk("show_on_done", 32'(bus.show_result), 32'd1);
        chk("disp_on_done", 32'(bus.disp_bcd), 32'(to_bcd(e.val)));
      end
    end
  end

  task automatic pulse_inc(input logic [2*D-1:0] bits);
    @(posedge clk); #1;
    bus.inc = bits;
    @(posedge clk); #1;
    bus.inc = '0;
    for (int i = 0; i < D; i++) begin
      if (bits[i])     mb[i] = (mb[i] + 1) % 10;
      if (bits[D + i]) ma[i] = (ma[i] + 1) % 10;
    end
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1;
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    for (int i = 0; i < D; i++) begin
      ma[i] = 0;
      mb[i] = 0;
    end
  endtask

  task automatic set_ops(input int av, input int bv);
    logic [2*D-1:0] bits;
    int ta, tb;
    bit any;
    any = 1'b0;
    for (int k = 0; k < 10; k++) begin
      bits = '0;
      ta = av;
      tb = bv;
      for (int i = 0; i < D; i++) begin
        if (mb[i] != tb % 10) bits[i] = 1'b1;
        if (ma[i] != ta % 10) bits[D + i] = 1'b1;
        ta = ta / 10;
        tb = tb / 10;
      end
      if (bits == '0) break;
      pulse_inc(bits);
      any = 1'b1;
    end
    if (any) begin
      @(negedge clk);
      chk("disp_operands", 32'(bus.disp_bcd), 32'(opnd_bcd()));
    end
  endtask

  task automatic issue_op(input logic [1:0] opc, input logic [2*D-1:0] incb, input bit push);
    exp_t e;
    int a, b;
    @(posedge clk); #1;
    bus.op_valid = 1'b1;
    bus.op       = opc;
    bus.inc      = incb;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    bus.inc      = '0;
    a = val_a();
    b = val_b();
    e.neg = 1'b0;
    e.err = 1'b0;
    e.lat = LAT_S;
    e.acc = cyc;
    case (opc)
      2'd0: e.val = a + b;
      2'd1: begin e.neg = (a < b); e.val = (a < b) ? b - a : a - b; end
      2'd2: e.val = a * b;
      default: if (b == 0) begin e.val = 0; e.err = 1'b1; end
               else begin e.val = (2 * a + b) / (2 * b); e.lat = LAT_DIV; end
    endcase
    if (push) sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 80; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout pending=%0d", sb.size());
      sb.delete();
    end
  endtask

  task automatic run(input int av, input int bv, input logic [1:0] opc);
    set_ops(av, bv);
    issue_op(opc, '0, 1'b1);
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.inc = '0;
    bus.clear = 1'b0;
    bus.op_valid = 1'b0;
    bus.op = 2'd0;
    for (int i = 0; i < D; i++) begin ma[i] = 0; mb[i] = 0; end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_op_ready", 32'(bus.op_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_res", 32'(bus.res_bcd), 32'd0);
    chk("rst_show", 32'(bus.show_result), 32'd0);
    chk("rst_disp", 32'(bus.disp_bcd), 32'd0);
    rst_n = 1'b1;

    run(47, 58, 2'd0);
    run(12, 34, 2'd1);
    run(34, 34, 2'd1);
    run(99, 99, 2'd2);
    pulse_inc(4'b0001);
    @(negedge clk);
    chk("wrap_show", 32'(bus.show_result), 32'd0);
    chk("wrap_disp", 32'(bus.disp_bcd), 32'h9990);

    run(7, 2, 2'd3);
    run(10, 3, 2'd3);
    run(5, 0, 2'd3);
    run(11, 2, 2'd3);

    // Clear mid-divide: no done, operands zeroed, previous result retained.
    set_ops(7, 2);
    issue_op(2'd3, '0, 1'b0);
    repeat (3) @(posedge clk);
    pulse_clear();
    @(negedge clk);
    chk("clr_op_ready", 32'(bus.op_ready), 32'd1);
    chk("clr_busy", 32'(bus.busy), 32'd0);
    chk("clr_disp", 32'(bus.disp_bcd), 32'd0);
    chk("clr_res_kept", 32'(bus.res_bcd), 32'h0006);
    repeat (30) @(negedge clk);

    // Asynchronous reset during CONV.
    run(5, 0, 2'd3);
    set_ops(23, 45);
    issue_op(2'd0, '0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst_op_ready", 32'(bus.op_ready), 32'd1);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_res", 32'(bus.res_bcd), 32'd0);
    chk("arst_err", 32'(bus.res_err), 32'd0);
    chk("arst_disp", 32'(bus.disp_bcd), 32'd0);
    for (int i = 0; i < D; i++) begin ma[i] = 0; mb[i] = 0; end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Same-cycle inc is dropped; inc/op_valid while busy are ignored.
    set_ops(12, 34);
    issue_op(2'd0, 4'b1000, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      bus.op_valid = 1'b1;
      bus.op = 2'($urandom_range(0, 3));
      bus.inc = 4'($urandom_range(1, 15));
    end
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    bus.inc = '0;
    drain();
    issue_op(2'd1, '0, 1'b1);
    drain();

    for (int n = 0; n < 40; n++) begin
      int av, bv;
      av = $urandom_range(0, 99);
      bv = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 99);
      run(av, bv, 2'($urandom_range(0, 3)));
    end

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
